// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer (master) and the ARM-subset
// datapath (slave): instruction fields and memory ready in, mux selects and strobes out.
interface multicycle_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         op;
  logic [5:0]         funct;
  logic [3:0]         rd;
  logic               mem_ready;

  logic               mem_req;
  logic               ir_write;
  logic               next_pc;
  logic               adr_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         result_src;
  logic [1:0]         alu_control;
  logic [1:0]         flag_w;
  logic               pcs;
  logic               reg_w;
  logic               mem_w;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, funct, rd, mem_ready,
    output mem_req, ir_write, next_pc, adr_src, alu_src_a, alu_src_b,
           result_src, alu_control, flag_w, pcs, reg_w, mem_w, state
  );

  modport slave (
    output op, funct, rd, mem_ready,
    input  mem_req, ir_write, next_pc, adr_src, alu_src_a, alu_src_b,
           result_src, alu_control, flag_w, pcs, reg_w, mem_w, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle ARM-subset datapath with a ready-based memory handshake.
// Optional retired-instruction counter enabled by MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MULTICYCLE_CTRL_PERF_EN
  output logic [31:0] instr_count_o,
`endif
  multicycle_ctrl_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    UNDEF    = STATE_W'(10)
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
  } ctrl_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic [3:0] cmd;

  assign cmd = bus.funct[4:1];

  function automatic logic [1:0] alu_dec(input logic [3:0] c);
    case (c)
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b1010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  // CMP exists only to set flags, so it writes all four regardless of S.
  function automatic logic [1:0] flag_dec(input logic [3:0] c, input logic s);
    logic [1:0] a;
    a = alu_dec(c);
    if (c == CMD_CMP)                     flag_dec = 2'b11;
    else if (!s)                          flag_dec = 2'b00;
    else if (a == ALU_AND || a == ALU_ORR) flag_dec = 2'b10;
    else                                  flag_dec = 2'b11;
  endfunction

  // NOTE: the state register uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // NOTE: state_d and ctrl get defaults first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ctrl.ir_write   = 1'b1;
          ctrl.next_pc    = 1'b1;
          ctrl.alu_src_a  = 1'b1;
          ctrl.alu_src_b  = 2'b10;
          ctrl.result_src = 2'b10;
          state_d         = DECODE;
        end
      end
      DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        case (bus.op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = bus.funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNDEF;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_b = 2'b01;
        state_d        = bus.funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_w      = 1'b1;
        ctrl.pcs        = (bus.rd == 4'hF);
        state_d         = FETCH;
      end
      MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXECR, EXECI: begin
        ctrl.alu_src_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
        ctrl.alu_control = alu_dec(cmd);
        ctrl.flag_w      = flag_dec(cmd, bus.funct[0]);
        state_d          = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_w = (cmd != CMD_CMP);
        ctrl.pcs   = (cmd != CMD_CMP) && (bus.rd == 4'hF);
        state_d    = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_b  = 2'b01;
        ctrl.result_src = 2'b10;
        ctrl.pcs        = 1'b1;
        state_d         = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Reset also silences the FETCH memory request that the idle state would otherwise raise.
    if (!reset) ctrl = '0;
  end

  assign bus.mem_req     = ctrl.mem_req;
  assign bus.ir_write    = ctrl.ir_write;
  assign bus.next_pc     = ctrl.next_pc;
  assign bus.adr_src     = ctrl.adr_src;
  assign bus.alu_src_a   = ctrl.alu_src_a;
  assign bus.alu_src_b   = ctrl.alu_src_b;
  assign bus.result_src  = ctrl.result_src;
  assign bus.alu_control = ctrl.alu_control;
  assign bus.flag_w      = ctrl.flag_w;
  assign bus.pcs         = ctrl.pcs;
  assign bus.reg_w       = ctrl.reg_w;
  assign bus.mem_w       = ctrl.mem_w;
  assign bus.state       = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] count_q;
  logic        retire;

  assign retire = (state_q inside {MEMWB, MEMWRITE, ALUWB, BRANCH, UNDEF}) &&
                  (state_d == FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count_q <= '0;
    else if (retire) count_q <= count_q + 32'd1;
  end

  assign instr_count_o = count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions then random ones,
// each expanded into an expected per-cycle control trace from the instruction semantics.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, irw, npc, adrs, sa;
    logic [1:0] sb, rs, alu, fw;
    logic       pcs, rw, mw;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.STATE_W(4)) bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instr_count;
`endif

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef MULTICYCLE_CTRL_PERF_EN
    .instr_count_o (instr_count),
`endif
    .bus           (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned model_count = 0;
  cyc_t        exp_q[$];
  bit          mr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [19:0] observed();
    return {bus.state, bus.mem_req, bus.ir_write, bus.next_pc, bus.adr_src, bus.alu_src_a,
            bus.alu_src_b, bus.result_src, bus.alu_control, bus.flag_w,
            bus.pcs, bus.reg_w, bus.mem_w};
  endfunction

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t c = '0;
    c.st = st;
    return c;
  endfunction

  task automatic push(input cyc_t c, input bit mr);
    exp_q.push_back(c);
    mr_q.push_back(mr);
  endtask

  // Expected trace of one instruction: wf wait cycles in fetch, wm in the data access.
  task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                       input int wf, input int wm);
    cyc_t       c;
    logic [3:0] cmd = funct[4:1];
    bit         is_cmp = (cmd == 4'b1010);
    for (int i = 0; i < wf; i++) begin
      c = blank(4'd0); c.mreq = 1; push(c, 1'b0);
    end
    c = blank(4'd0);
    c.mreq = 1; c.irw = 1; c.npc = 1; c.sa = 1; c.sb = 2'b10; c.rs = 2'b10;
    push(c, 1'b1);
    c = blank(4'd1); c.sa = 1; c.sb = 2'b10; c.rs = 2'b10;
    push(c, 1'($urandom_range(0, 1)));
    case (op)
      2'b01: begin
        c = blank(4'd2); c.sb = 2'b01; push(c, 1'($urandom_range(0, 1)));
        if (funct[0]) begin
          for (int i = 0; i <= wm; i++) begin
            c = blank(4'd3); c.mreq = 1; c.adrs = 1; push(c, i == wm);
          end
          c = blank(4'd4); c.rs = 2'b01; c.rw = 1; c.pcs = (rd == 4'd15);
          push(c, 1'($urandom_range(0, 1)));
        end else begin
          for (int i = 0; i <= wm; i++) begin
            c = blank(4'd5); c.mreq = 1; c.adrs = 1; c.mw = 1; push(c, i == wm);
          end
        end
      end
      2'b00: begin
        c = blank(funct[5] ? 4'd7 : 4'd6);
        c.sb = funct[5] ? 2'b01 : 2'b00;
        case (cmd)
          4'b0010, 4'b1010: c.alu = 2'b01;
          4'b0000:          c.alu = 2'b10;
          4'b1100:          c.alu = 2'b11;
          default:          c.alu = 2'b00;
        endcase
        if (is_cmp)           c.fw = 2'b11;
        else if (!funct[0])   c.fw = 2'b00;
        else if (c.alu[1])    c.fw = 2'b10;
        else                  c.fw = 2'b11;
        push(c, 1'($urandom_range(0, 1)));
        c = blank(4'd8); c.rw = !is_cmp; c.pcs = !is_cmp && (rd == 4'd15);
        push(c, 1'($urandom_range(0, 1)));
      end
      2'b10: begin
        c = blank(4'd9); c.sb = 2'b01; c.rs = 2'b10; c.pcs = 1;
        push(c, 1'($urandom_range(0, 1)));
      end
      default: begin
        push(blank(4'd10), 1'($urandom_range(0, 1)));
      end
    endcase
  endtask

  // Entered at a negedge; plays up to n cycles of the trace (all if n<0), ends at a negedge.
  task automatic play(input string name, input logic [1:0] op, input logic [5:0] funct,
                      input logic [3:0] rd, input int n);
    int k = 0;
    bus.op = op; bus.funct = funct; bus.rd = rd;
`ifdef MULTICYCLE_CTRL_PERF_EN
    check({name, " instr_count"}, instr_count, model_count);
`endif
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      bus.mem_ready = mr_q.pop_front();
      #1;
      check($sformatf("%s cyc%0d", name, k), {12'd0, observed()}, {12'd0, exp_q.pop_front()});
      k++;
      @(negedge clk);
    end
    if (n < 0) model_count++;
    exp_q.delete();
    mr_q.delete();
  endtask

  task automatic instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input int wf, input int wm);
    build(op, funct, rd, wf, wm);
    play(name, op, funct, rd, -1);
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check($sformatf("reset cyc%0d", i), {12'd0, observed()}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
      check("reset instr_count", instr_count, 32'd0);
`endif
      @(negedge clk);
    end
    model_count = 0;
    reset = 1'b1;
  endtask

  initial begin
    bus.op = 2'b00; bus.funct = '0; bus.rd = '0; bus.mem_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset_cycles(3);

    instr("add_imm_r1", 2'b00, 6'b001000, 4'd1,  0, 0);
    instr("subs_r15",   2'b00, 6'b000101, 4'd15, 1, 0);
    instr("ldr_wait",   2'b01, 6'b011001, 4'd3,  0, 2);
    instr("ldr_pc",     2'b01, 6'b011001, 4'd15, 0, 0);
    instr("str",        2'b01, 6'b011000, 4'd4,  0, 1);
    instr("branch",     2'b10, 6'b000000, 4'd0,  2, 0);
    instr("cmp",        2'b00, 6'b010100, 4'd15, 0, 0);
    instr("undef",      2'b11, 6'b000000, 4'd0,  0, 0);
    instr("orrs",       2'b00, 6'b111001, 4'd6,  0, 0);
    instr("ands_reg",   2'b00, 6'b000001, 4'd7,  0, 0);

    // Abort a store in its data phase: reset must drop every strobe immediately.
    build(2'b01, 6'b011000, 4'd2, 0, 3);
    play("str_abort", 2'b01, 6'b011000, 4'd2, 4);
    reset_cycles(2);
    instr("after_abort", 2'b00, 6'b101001, 4'd8, 0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] op    = 2'($urandom_range(0, 3));
      logic [5:0] funct = 6'($urandom);
      logic [3:0] rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      instr($sformatf("rand%0d", i), op, funct, rd, $urandom_range(0, 2), $urandom_range(0, 2));
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    check("final instr_count", instr_count, model_count);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main sequencing FSM for the multicycle ARM-subset datapath.
- Walks each instruction through its phases: fetch, decode, execute/address, memory, writeback.
- Drives the datapath mux selects and the ALU control.
- Produces raw pcs/reg_w/mem_w strobes, which the condition logic gates with the condition-pass signal.
- Handles a ready-based memory handshake so one shared memory can be used for both instructions and data.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  2  instruction bits [27:26]
- funct  in  6  instruction bits [25:20]: [5]=I, [4:1]=cmd, [0]=S/L
- rd  in  4  destination register field
- mem_ready  in  1  memory access completes in the cycle it is 1
- mem_req  out  1  memory access requested
- ir_write  out  1  load instruction register
- next_pc  out  1  unconditional PC write (fetch increment)
- adr_src  out  1  0=PC, 1=ALUOut
- alu_src_a  out  1  0=Rn, 1=PC
- alu_src_b  out  2  00=Rm, 01=ExtImm, 10=const 4
- result_src  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- alu_control  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- flag_w  out  2  [1]=write N,Z; [0]=write C,V
- pcs  out  1  raw PC-source strobe (branch or write to R15)
- reg_w  out  1  raw register-write strobe
- mem_w  out  1  raw memory-write strobe
- state  out  STATE_W  current state, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNDEF=10. Encodings 11–15 go to FETCH.
- Reset:
  - While reset=0, state=FETCH and every output is 0, including mem_req.
  - Asserting reset mid-instruction aborts the instruction immediately. No strobe is emitted.
- Outputs are combinational from state, funct, rd and mem_ready. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, adr_src=0.
  - The FSM holds in FETCH while mem_ready=0.
  - In the cycle mem_ready=1: ir_write=1, next_pc=1, alu_src_a=1, alu_src_b=10, result_src=10, alu_control=ADD. Next state is DECODE.
- DECODE:
  - alu_src_a=1, alu_src_b=10, result_src=10, ADD.
  - Transitions: op=01 → MEMADR; op=00 with funct[5]=0 → EXECR; op=00 with funct[5]=1 → EXECI; op=10 → BRANCH; op=11 → UNDEF.
- MEMADR: alu_src_a=0, alu_src_b=01, ADD. Goes to MEMREAD if funct[0]=1, else MEMWRITE.
- MEMREAD:
  - mem_req=1, adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
  - A pending mem_ready is not sampled outside MEMREAD, MEMWRITE and FETCH.
- MEMWB: result_src=01, reg_w=1, pcs=(rd==15). Goes to FETCH.
- MEMWRITE:
  - mem_req=1, adr_src=1, mem_w=1 in every cycle of the state.
  - The write commits in the mem_ready=1 cycle, then goes to FETCH.
- EXECR / EXECI:
  - alu_src_a=0. alu_src_b=00 in EXECR, 01 in EXECI.
  - cmd decode: 0100 ADD → ADD; 0010 SUB → SUB; 1010 CMP → SUB; 0000 AND → AND; 1100 ORR → ORR; any other cmd → ADD.
  - flag_w=00 if funct[0]=0. Otherwise flag_w=11 for ADD/SUB/CMP and 10 for AND/ORR.
  - CMP always has flag_w=11, regardless of funct[0].
  - Goes to ALUWB.
- ALUWB:
  - result_src=00.
  - reg_w=1 unless cmd=1010. pcs=(rd==15 and reg_w).
  - Goes to FETCH.
- BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, pcs=1. Goes to FETCH.
- UNDEF: all outputs 0 for one cycle, then FETCH.
- Cycle counts with mem_ready held at 1: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 3.
- Each extra cycle of mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined:
  - Adds output instr_count [31:0].
  - Counter resets to 0 on reset=0.
  - Increments by 1 on every clock edge where the FSM leaves MEMWB, MEMWRITE (with mem_ready=1), ALUWB, BRANCH or UNDEF for FETCH.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset held low for 3 cycles, then released with mem_ready=1 → during reset, state=0 and all outputs 0; first cycle after release, mem_req=1 and ir_write=1.
- ADD R1 with op=00, funct=001000 (immediate, S=0), rd=1, mem_ready=1 → state sequence 0,1,7,8,0; ALUWB has reg_w=1, pcs=0; flag_w=00 throughout.
- SUBS R15 with op=00, funct=000101, rd=15 → EXECR has alu_control=01, flag_w=11; ALUWB has reg_w=1, pcs=1.
- LDR with op=01, funct=011001, mem_ready low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles with mem_req=1 and adr_src=1; MEMWB has result_src=01, reg_w=1.
- STR with op=01, funct=011000 → MEMWRITE has mem_w=1, reg_w=0; returns to FETCH. Then B with op=10 → BRANCH has pcs=1, result_src=10.
- CMP with funct=010101, followed by op=11 → ALUWB has reg_w=0; then UNDEF for 1 cycle with all outputs 0. With MULTICYCLE_CTRL_PERF_EN defined, instr_count goes 0→2.
